// File: rtl/countdown_64.sv
// Loadable down-counter with pause and abort; emits a one-cycle done pulse
// when a countdown of N cycles completes. clr is an asynchronous active-low reset.
//
// state | meaning
// IDLE  | no countdown active, q = 0
// RUN   | counting down from the loaded length, q > 0
// DONE  | countdown just completed, done pulse for one cycle
module countdown_64 #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [WIDTH-1:0] cycles,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             tc
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  // Abort is checked first so it beats both pause and a same-cycle start.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
      q     <= '0;
    end else if (abort) begin
      state <= IDLE;
      q     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            if (cycles != '0) begin
              q     <= cycles;
              state <= RUN;
            end else begin
              q     <= '0;
              state <= DONE;
            end
          end else begin
            q     <= '0;
            state <= IDLE;
          end
        end
        RUN: begin
          if (!pause) begin
            if (q > WIDTH'(1)) begin
              q <= q - WIDTH'(1);
            end else begin
              q     <= '0;
              state <= DONE;
            end
          end
        end
        default: begin
          state <= IDLE;
          q     <= '0;
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
    tc   = (q == '0);
  end

endmodule

// File: tb/tb_countdown_64.sv
// Directed bench for countdown_64: hand-computed sequences for load, count,
// pause, abort, back-to-back starts and asynchronous reset.
module tb_countdown_64;

  logic       clk;
  logic       clr;
  logic       start;
  logic [6:0] cycles;
  logic       pause;
  logic       abort;
  logic [6:0] q;
  logic       busy;
  logic       done;
  logic       tc;

  int n_tests = 0;
  int n_fail  = 0;

  countdown_64 #(.WIDTH(7)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .cycles (cycles),
    .pause  (pause),
    .abort  (abort),
    .q      (q),
    .busy   (busy),
    .done   (done),
    .tc     (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int eq, input int eb, input int ed, input int et);
    check({tag, ".q"}, int'(q), eq);
    check({tag, ".busy"}, int'(busy), eb);
    check({tag, ".done"}, int'(done), ed);
    check({tag, ".tc"}, int'(tc), et);
  endtask

  initial begin
    int bad;
    int seen_done;

    clr = 1'b0; start = 1'b0; cycles = '0; pause = 1'b0; abort = 1'b0;
    #2;
    check_out("reset", 0, 0, 0, 1);
    start = 1'b1; cycles = 7'd5;
    tick();
    check_out("reset_hold", 0, 0, 0, 1);
    start = 1'b0;
    #2 clr = 1'b1;

    // basic countdown of 5, cycles changed mid-run must not matter
    start = 1'b1; cycles = 7'd5;
    tick();
    start = 1'b0; cycles = 7'd100;
    check_out("basic_load", 5, 1, 0, 0);
    for (int i = 4; i >= 1; i--) begin
      tick();
      check_out("basic_run", i, 1, 0, 0);
    end
    tick();
    check_out("basic_done", 0, 0, 1, 1);
    tick();
    check_out("basic_idle", 0, 0, 0, 1);

    // zero length
    start = 1'b1; cycles = 7'd0;
    tick();
    start = 1'b0;
    check_out("zero_done", 0, 0, 1, 1);
    tick();
    check_out("zero_idle", 0, 0, 0, 1);

    // maximum length
    start = 1'b1; cycles = 7'd127;
    tick();
    start = 1'b0;
    check_out("max_load", 127, 1, 0, 0);
    bad = 0;
    for (int i = 1; i <= 126; i++) begin
      tick();
      if (int'(q) != 127 - i || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    check("max_seq", bad, 0);
    tick();
    check_out("max_done", 0, 0, 1, 1);
    tick();
    check_out("max_idle", 0, 0, 0, 1);

    // pause for three cycles at q=3
    start = 1'b1; cycles = 7'd4;
    tick();
    start = 1'b0;
    check_out("pause_load", 4, 1, 0, 0);
    tick();
    check_out("pause_q3", 3, 1, 0, 0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("pause_hold", 3, 1, 0, 0);
    end
    pause = 1'b0;
    tick();
    check_out("pause_q2", 2, 1, 0, 0);
    tick();
    check_out("pause_q1", 1, 1, 0, 0);
    tick();
    check_out("pause_done", 0, 0, 1, 1);
    tick();

    // abort at q=6
    start = 1'b1; cycles = 7'd10;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_out("abort_q6", 6, 1, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_out("abort_idle", 0, 0, 0, 1);
    seen_done = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done === 1'b1) seen_done++;
    end
    check("abort_no_done", seen_done, 0);

    // abort and start together in IDLE
    abort = 1'b1; start = 1'b1; cycles = 7'd9;
    tick();
    abort = 1'b0; start = 1'b0;
    check_out("abort_start", 0, 0, 0, 1);

    // abort overrides pause
    start = 1'b1; cycles = 7'd8;
    tick();
    start = 1'b0; pause = 1'b1; abort = 1'b1;
    tick();
    pause = 1'b0; abort = 1'b0;
    check_out("abort_pause", 0, 0, 0, 1);

    // start ignored in RUN, then back-to-back start in DONE
    start = 1'b1; cycles = 7'd3;
    tick();
    check_out("ign_load", 3, 1, 0, 0);
    cycles = 7'd9;
    tick();
    start = 1'b0;
    check_out("ign_q2", 2, 1, 0, 0);
    tick();
    check_out("ign_q1", 1, 1, 0, 0);
    tick();
    check_out("ign_done", 0, 0, 1, 1);
    start = 1'b1; cycles = 7'd2;
    tick();
    start = 1'b0;
    check_out("b2b_load", 2, 1, 0, 0);
    tick();
    check_out("b2b_q1", 1, 1, 0, 0);
    tick();
    check_out("b2b_done", 0, 0, 1, 1);
    tick();
    check_out("b2b_idle", 0, 0, 0, 1);

    // asynchronous reset mid-countdown at q=12
    start = 1'b1; cycles = 7'd20;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_out("arst_q12", 12, 1, 0, 0);
    #2 clr = 1'b0;
    #1;
    check_out("arst_now", 0, 0, 0, 1);
    start = 1'b1; cycles = 7'd3;
    tick();
    start = 1'b0;
    check_out("arst_held", 0, 0, 0, 1);
    #2 clr = 1'b1;
    seen_done = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    check("arst_no_done", seen_done, 0);

    // first edge after release may accept a start
    clr = 1'b0;
    #2 clr = 1'b1;
    start = 1'b1; cycles = 7'd1;
    tick();
    start = 1'b0;
    check_out("rel_load", 1, 1, 0, 0);
    tick();
    check_out("rel_done", 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, %0d run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

endmodule
